// File: rtl/fp_chk_pkg.sv
// Shared types and encodings for the floating-point vector checker.
package fp_chk_pkg;

  localparam int FLAG_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RZ  = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_SQRT = 3'b100;

endpackage

// File: rtl/fp_chk_delay.sv
// Tagged delay line: LAT register stages with per-stage valid, or a wire when LAT=0.
// Valid bits clear on reset; data is only meaningful alongside its valid bit.
module fp_chk_delay #(
  parameter int W   = 8,
  parameter int LAT = 0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  if (LAT == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ reset_i;
    assign vld_o = vld_i;
    assign dat_o = dat_i;
  end else begin : g_pipe
    logic [LAT-1:0] vld_q;
    logic [W-1:0]   dat_q [LAT];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= vld_i;
        for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      dat_q[0] <= dat_i;
      for (int i = 1; i < LAT; i++) dat_q[i] <= dat_q[i-1];
    end

    assign vld_o = vld_q[LAT-1];
    assign dat_o = dat_q[LAT-1];
  end

endmodule

// File: rtl/fp_vec_checker.sv
// Streams test vectors into an FP unit and checks its results after DUT_LAT cycles.
// Define FP_CHK_FLAGS_EN to also compare the five exception flags.
module fp_vec_checker
  import fp_chk_pkg::*;
#(
  parameter int FW      = 32,
  parameter int DEPTH   = 1024,
  parameter int DUT_LAT = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             cfg_rm,
  input  logic [2:0]             cfg_op,
  output logic [AW-1:0]          vec_addr,
  input  logic [3*FW+FLAG_W-1:0] vec_data,
  input  logic                   vec_valid,
  output logic [FW-1:0]          op1,
  output logic [FW-1:0]          op2,
  output logic [2:0]             rm,
  output logic [2:0]             op_type,
  input  logic [FW-1:0]          dut_result,
  input  logic [FLAG_W-1:0]      dut_flags,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            vec_count,
  output logic [31:0]            err_count,
  output logic                   err_pulse,
  output logic [AW-1:0]          err_index
);

  localparam int VW = 3*FW + FLAG_W;
`ifdef FP_CHK_FLAGS_EN
  localparam int TW = FW + FLAG_W + AW;
`else
  localparam int TW = FW + AW;
`endif
  localparam logic [2:0] DRAIN_LAST = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [2:0]    rm_q, op_q, drain_q;
  logic [31:0]   vec_count_q, vec_count_d, err_count_q, err_count_d;
  logic          err_pulse_q;
  logic [AW-1:0] err_index_q;

  logic          issue, last, start_acc, mismatch;
  logic [TW-1:0] tag_in, tag_out;
  logic          tag_vld;
  logic [FW-1:0] tag_exp;
  logic [AW-1:0] tag_idx;

  assign issue     = (state_q == S_ISSUE) && vec_valid;
  assign last      = (addr_q == AW'(DEPTH - 1));
  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef FP_CHK_FLAGS_EN
  assign tag_in   = {vec_data[FLAG_W +: FW], vec_data[FLAG_W-1:0], addr_q};
  assign mismatch = tag_vld && ((dut_result != tag_exp) ||
                                (dut_flags != tag_out[AW +: FLAG_W]));
`else
  logic unused_flags;
  assign unused_flags = ^{vec_data[FLAG_W-1:0], dut_flags};
  assign tag_in   = {vec_data[FLAG_W +: FW], addr_q};
  assign mismatch = tag_vld && (dut_result != tag_exp);
`endif

  assign tag_exp = tag_out[TW-1 -: FW];
  assign tag_idx = tag_out[AW-1:0];

  fp_chk_delay #(.W(TW), .LAT(DUT_LAT)) u_dly (
    .clk_i   (clk),
    .reset_i (reset),
    .vld_i   (issue),
    .dat_i   (tag_in),
    .vld_o   (tag_vld),
    .dat_o   (tag_out)
  );

  // Counters saturate rather than wrap so a long soak never reports a false zero.
  always_comb begin
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    if (start_acc) begin
      vec_count_d = '0;
      err_count_d = '0;
    end else if (tag_vld) begin
      if (vec_count_q != 32'hFFFF_FFFF) vec_count_d = vec_count_q + 32'd1;
      if (mismatch && (err_count_q != 32'hFFFF_FFFF)) err_count_d = err_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rm_q        <= '0;
      op_q        <= '0;
      drain_q     <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      err_index_q <= '0;
    end else begin
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      err_pulse_q <= mismatch;
      if (mismatch) err_index_q <= tag_idx;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            rm_q    <= cfg_rm;
            op_q    <= cfg_op;
            addr_q  <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (vec_valid && !last) addr_q <= addr_q + 1'b1;
          if (!vec_valid || last) begin
            drain_q <= '0;
            state_q <= (DUT_LAT == 0) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) state_q <= S_DONE;
          else drain_q <= drain_q + 3'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_addr  = addr_q;
  assign op1       = issue ? vec_data[VW-1 -: FW] : '0;
  assign op2       = issue ? vec_data[VW-1-FW -: FW] : '0;
  assign rm        = rm_q;
  assign op_type   = op_q;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign vec_count = vec_count_q;
  assign err_count = err_count_q;
  assign err_pulse = err_pulse_q;
  assign err_index = err_index_q;

endmodule

// File: tb/tb_fp_vec_checker.sv
// Bench for fp_vec_checker: three instances (latency 0, 3 and 2/DEPTH=4) driven from one vector memory.
module tb_fp_vec_checker;

  localparam logic [2:0] RZ  = 3'b001;
  localparam logic [2:0] SUB = 3'b001;
`ifdef FP_CHK_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] expv;
    logic [4:0]  fl;
    logic        err;
    logic        ferr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, st0, st3, st2;
  logic [2:0]  cfg_rm, cfg_op;
  logic [100:0] mem [16];
  logic [15:0] vbits;
  int checks = 0;
  int errors = 0;
  vec_t tbl [6];

  // instance 0: DUT_LAT=0
  logic [3:0]  a0, ei0;
  logic [31:0] o10, o20, vc0, ec0;
  logic [2:0]  rm0, op0;
  logic        bz0, dn0, ep0;
  // instance 3: DUT_LAT=3
  logic [3:0]  a3, ei3;
  logic [31:0] o13, o23, vc3, ec3, r3a, r3b, r3c;
  logic [4:0]  f3a, f3b, f3c;
  logic [2:0]  rm3, op3;
  logic        bz3, dn3, ep3;
  // instance 2: DUT_LAT=2, DEPTH=4
  logic [1:0]  a2, ei2;
  logic [31:0] o12, o22, vc2, ec2, r2a, r2b;
  logic [4:0]  f2a, f2b;
  logic [2:0]  rm2, op2;
  logic        bz2, dn2, ep2;

  always @(posedge clk) begin
    r3a <= o13 + o23; r3b <= r3a; r3c <= r3b;
    f3a <= o23[4:0];  f3b <= f3a; f3c <= f3b;
    r2a <= o12 + o22; r2b <= r2a;
    f2a <= o22[4:0];  f2b <= f2a;
  end

  fp_vec_checker #(.FW(32), .DEPTH(16), .DUT_LAT(0)) u0 (
    .clk(clk), .reset(reset), .start(st0), .cfg_rm(cfg_rm), .cfg_op(cfg_op),
    .vec_addr(a0), .vec_data(mem[a0]), .vec_valid(vbits[a0]), .op1(o10), .op2(o20),
    .rm(rm0), .op_type(op0), .dut_result(o10 + o20), .dut_flags(o20[4:0]),
    .busy(bz0), .done(dn0), .vec_count(vc0), .err_count(ec0), .err_pulse(ep0), .err_index(ei0));

  fp_vec_checker #(.FW(32), .DEPTH(16), .DUT_LAT(3)) u3 (
    .clk(clk), .reset(reset), .start(st3), .cfg_rm(cfg_rm), .cfg_op(cfg_op),
    .vec_addr(a3), .vec_data(mem[a3]), .vec_valid(vbits[a3]), .op1(o13), .op2(o23),
    .rm(rm3), .op_type(op3), .dut_result(r3c), .dut_flags(f3c),
    .busy(bz3), .done(dn3), .vec_count(vc3), .err_count(ec3), .err_pulse(ep3), .err_index(ei3));

  fp_vec_checker #(.FW(32), .DEPTH(4), .DUT_LAT(2)) u2 (
    .clk(clk), .reset(reset), .start(st2), .cfg_rm(cfg_rm), .cfg_op(cfg_op),
    .vec_addr(a2), .vec_data(mem[a2]), .vec_valid(vbits[a2]), .op1(o12), .op2(o22),
    .rm(rm2), .op_type(op2), .dut_result(r2b), .dut_flags(f2b),
    .busy(bz2), .done(dn2), .vec_count(vc2), .err_count(ec2), .err_pulse(ep2), .err_index(ei2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int idx, input vec_t v);
    mem[idx]   = {v.op1, v.op2, v.expv, v.fl};
    vbits[idx] = 1'b1;
  endtask

  task automatic clear_mem();
    vbits = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  initial begin
    int   total;
    int   lastidx;
    logic e;

    tbl[0] = '{32'h3f800000, 32'h00000000, 32'h3f800000, 5'h00, 1'b0, 1'b0};
    tbl[1] = '{32'h40000000, 32'h00000003, 32'h40000003, 5'h03, 1'b0, 1'b0};
    tbl[2] = '{32'h3f800000, 32'h00000001, 32'h3f800000, 5'h01, 1'b1, 1'b0};
    tbl[3] = '{32'h12345678, 32'h11111111, 32'h23456789, 5'h11, 1'b0, 1'b0};
    tbl[4] = '{32'h00000010, 32'h00000000, 32'h00000010, 5'h01, 1'b0, 1'b1};
    tbl[5] = '{32'hffffffff, 32'h00000001, 32'h00000000, 5'h01, 1'b0, 1'b0};

    clear_mem();
    reset = 1'b1; st0 = 1'b1; st3 = 1'b0; st2 = 1'b0;
    cfg_rm = RZ; cfg_op = SUB;
    tick(); tick();
    // reset wins over start
    chk("rst_busy", 32'(bz0), 0);
    chk("rst_done", 32'(dn0), 0);
    chk("rst_addr", 32'(a0), 0);
    chk("rst_vcnt", vc0, 0);
    chk("rst_ecnt", ec0, 0);
    chk("rst_epulse", 32'(ep0), 0);
    chk("rst_eidx", 32'(ei0), 0);
    chk("rst_op1", o10, 0);
    chk("rst_rm", 32'(rm0), 0);
    st0 = 1'b0; reset = 1'b0;
    tick();
    chk("idle_busy", 32'(bz0), 0);

    // three matching vectors then terminator, latency 0
    load(0, tbl[0]); load(1, tbl[1]); load(2, tbl[3]);
    st0 = 1'b1; tick(); st0 = 1'b0;
    cfg_rm = 3'b100; cfg_op = 3'b100;
    chk("a_busy", 32'(bz0), 1);
    chk("a_rm", 32'(rm0), 32'(RZ));
    chk("a_op", 32'(op0), 32'(SUB));
    chk("a_op1", o10, tbl[0].op1);
    tick(); tick(); tick();
    chk("a_done_early", 32'(dn0), 0);
    chk("a_vcnt3", vc0, 3);
    tick();
    chk("a_done", 32'(dn0), 1);
    chk("a_busy_done", 32'(bz0), 0);
    chk("a_vcnt", vc0, 3);
    chk("a_ecnt", ec0, 0);
    chk("a_op1_idle", o10, 0);

    // table run, latency 0, restarted from DONE
    clear_mem();
    for (int i = 0; i < 6; i++) load(i, tbl[i]);
    st0 = 1'b1; tick(); st0 = 1'b0;
    total = 0; lastidx = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = tbl[i].err | (FLAGS & tbl[i].ferr);
      if (e) begin total++; lastidx = i; end
      chk($sformatf("t_pulse%0d", i), 32'(ep0), 32'(e));
      chk($sformatf("t_vcnt%0d", i), vc0, 32'(i + 1));
      chk($sformatf("t_ecnt%0d", i), ec0, 32'(total));
    end
    tick();
    chk("t_done", 32'(dn0), 1);
    chk("t_eidx", 32'(ei0), 32'(lastidx));
    chk("t_flag_ecnt", ec0, FLAGS ? 32'd2 : 32'd1);

    // latency 3, mismatch on vector 1
    clear_mem();
    load(0, tbl[0]); load(1, tbl[2]); load(2, tbl[3]);
    st3 = 1'b1; tick(); st3 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("l3_nopulse%0d", i), 32'(ep3), 0);
    end
    tick();
    chk("l3_pulse", 32'(ep3), 1);
    chk("l3_eidx", 32'(ei3), 1);
    chk("l3_ecnt", ec3, 1);
    tick();
    chk("l3_pulse_off", 32'(ep3), 0);
    chk("l3_drain_busy", 32'(bz3), 1);
    chk("l3_drain_done", 32'(dn3), 0);
    tick();
    chk("l3_done", 32'(dn3), 1);
    chk("l3_vcnt", vc3, 3);
    chk("l3_ecnt_end", ec3, 1);

    // DEPTH=4 with no terminator, latency 2
    clear_mem();
    load(0, tbl[0]); load(1, tbl[1]); load(2, tbl[3]); load(3, tbl[5]);
    st2 = 1'b1; tick(); st2 = 1'b0;
    tick(); tick(); tick();
    chk("d4_addr3", 32'(a2), 3);
    tick();
    chk("d4_addr_hold", 32'(a2), 3);
    chk("d4_drain_busy", 32'(bz2), 1);
    chk("d4_drain_vcnt", vc2, 2);
    tick();
    chk("d4_drain2", 32'(dn2), 0);
    tick();
    chk("d4_done", 32'(dn2), 1);
    chk("d4_vcnt", vc2, 4);
    chk("d4_ecnt", ec2, 0);
    chk("d4_addr_end", 32'(a2), 3);

    // reset mid-run with compares in flight
    clear_mem();
    for (int i = 0; i < 4; i++) load(i, tbl[2]);
    st2 = 1'b1; tick(); st2 = 1'b0;
    tick(); tick();
    chk("r_addr2", 32'(a2), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r_busy", 32'(bz2), 0);
    chk("r_done", 32'(dn2), 0);
    chk("r_vcnt", vc2, 0);
    chk("r_ecnt", ec2, 0);
    chk("r_pulse", 32'(ep2), 0);
    chk("r_addr", 32'(a2), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("r_nopend%0d", i), 32'(ep2) | vc2, 0);
    end

    // saturation of err_count
    clear_mem();
    load(0, tbl[0]); load(1, tbl[2]); load(2, tbl[2]); load(3, tbl[2]);
    st0 = 1'b1; tick(); st0 = 1'b0;
    force u0.err_count_q = 32'hFFFF_FFFE;
    tick();
    release u0.err_count_q;
    chk("s_preset", ec0, 32'hFFFF_FFFE);
    tick();
    chk("s_sat1", ec0, 32'hFFFF_FFFF);
    tick(); tick();
    chk("s_sat3", ec0, 32'hFFFF_FFFF);
    chk("s_pulse", 32'(ep0), 1);
    tick();
    chk("s_done", 32'(dn0), 1);
    chk("s_vcnt", vc0, 4);
    chk("s_ecnt", ec0, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
